// File: rtl/smips_pkg.sv
// Shared types and constants for the smips instruction-memory loader path.
package smips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int LOADER_CNT_W = 16;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/byte_packer.sv
// Collects four stream bytes MSB-first into a 32-bit word; word_valid marks
// the byte that completes the word, with the full word presented alongside it.
module byte_packer
  import smips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       flush,
  output logic       word_valid,
  output word_t      word
);

  logic [1:0]  lane;
  logic [23:0] shift_q;

  assign word_valid = byte_valid && (lane == 2'd3);
  assign word       = {shift_q, byte_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane    <= '0;
      shift_q <= '0;
    end else if (flush) begin
      lane    <= '0;
      shift_q <= '0;
    end else if (byte_valid) begin
      lane    <= lane + 2'd1;
      shift_q <= {shift_q[15:0], byte_data};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a counted, checksummed byte frame, writes the words
// into instruction memory and releases cpu_hold only after a clean load.
module imem_loader
  import smips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        start,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  loader_state_t state, next_state;

  logic                    alive;
  logic [7:0]              cnt_hi;
  logic [7:0]              csum;
  logic [LOADER_CNT_W-1:0] word_cnt;
  logic [LOADER_CNT_W-1:0] word_idx;
  logic [LOADER_CNT_W-1:0] n_words;
  logic                    accept;
  logic                    rearm;
  logic                    oversize;
  logic                    last_word;
  logic                    pack_valid;
  logic                    word_valid;
  word_t                   word;

  assign accept     = in_valid && in_ready;
  assign rearm      = start && ((state == DONE) || (state == ERR));
  assign n_words    = {cnt_hi, in_data};
  assign oversize   = {{(32-LOADER_CNT_W){1'b0}}, n_words} > MAX_WORDS;
  assign last_word  = (word_idx + LOADER_CNT_W'(1)) == word_cnt;
  assign pack_valid = accept && (state == DATA);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .flush      (rearm),
    .word_valid (word_valid),
    .word       (word)
  );

  // Keeps in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = CNT;
      CNT: begin
        if (accept) begin
          if (oversize)              next_state = ERR;
          else if (n_words == '0)    next_state = CSUM;
          else                       next_state = DATA;
        end
      end
      DATA: if (word_valid && last_word) next_state = CSUM;
      CSUM: if (accept) next_state = (in_data == csum) ? DONE : ERR;
      DONE, ERR: if (start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = alive && ((state == IDLE) || (state == CNT) ||
                         (state == DATA) || (state == CSUM));
  end

  // Count capture, running checksum and word index; the checksum byte itself
  // is compared, never folded in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_hi   <= '0;
      word_cnt <= '0;
      word_idx <= '0;
      csum     <= '0;
    end else if (rearm) begin
      word_idx <= '0;
      csum     <= '0;
    end else begin
      if (accept && (state != CSUM)) csum <= csum ^ in_data;
      if (accept && (state == IDLE)) cnt_hi <= in_data;
      if (accept && (state == CNT))  word_cnt <= n_words;
      if (word_valid)                word_idx <= word_idx + LOADER_CNT_W'(1);
    end
  end

  // Status follows next_state so done/error/cpu_hold move one cycle after
  // the checksum byte, after the last word's write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_en <= word_valid;
      if (word_valid) begin
        wr_addr <= BASE_ADDR + {{(30-LOADER_CNT_W){1'b0}}, word_idx, 2'b00};
        wr_data <= word;
      end
      done     <= (next_state == DONE);
      error    <= (next_state == ERR);
      cpu_hold <= (next_state != DONE);
    end
  end

endmodule
